// File: rtl/add_accum_unit.sv
// rtl/add_accum_unit.sv - two-stage add/sub/accumulate unit with saturation and sticky carry
// S1 registers operands; S2 computes, registers result/carry and updates the accumulator.
module add_accum_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_DACC = 2'b11
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic             s1_sat;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_is_sub;
  logic             s2_is_acc;
  logic [WIDTH:0]   s2_x;
  logic [WIDTH:0]   s2_y;
  logic [WIDTH:0]   s2_sum;
  logic             s2_carry;
  logic [WIDTH-1:0] s2_result;

  assign s2_is_sub = (s1_op == OP_SUB) || (s1_op == OP_DACC);
  assign s2_is_acc = (s1_op == OP_ACC) || (s1_op == OP_DACC);

  // Accumulate ops read the live accumulator, so back-to-back ACCs chain without bubbles.
  assign s2_x = {1'b0, (s2_is_acc ? acc  : s1_a)};
  assign s2_y = {1'b0, (s2_is_acc ? s1_a : s1_b)};

  // Bit WIDTH is the carry for a sum and the borrow for a zero-extended difference.
  assign s2_sum   = s2_is_sub ? (s2_x - s2_y) : (s2_x + s2_y);
  assign s2_carry = s2_sum[WIDTH];

  always_comb begin
    s2_result = s2_sum[WIDTH-1:0];
    if (s1_sat && s2_carry) begin
      s2_result = s2_is_sub ? '0 : '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_ADD;
      s1_sat     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      carry      <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
    end else if (ena) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= op_e'(op);
        s1_sat <= sat;
        s1_a   <= a;
        s1_b   <= b;
      end

      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= s2_result;
        carry  <= s2_carry;
      end

      // clr wins over a same-cycle accumulator write and carry.
      if (clr) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end else if (s1_valid) begin
        if (s2_is_acc) begin
          acc <= s2_result;
        end
        if (s2_carry) begin
          ovf_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_accum_unit.sv
// tb/tb_add_accum_unit.sv - directed vectors, multi-cycle corner cases and a random stream
module tb_add_accum_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b1;
  logic         in_valid = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         sat = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         clr = 1'b0;
  logic         out_valid;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf_sticky;
  logic [W-1:0] acc;

  int checks = 0;
  int failures = 0;

  add_accum_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .op(op), .sat(sat),
    .a(a), .b(b), .clr(clr), .out_valid(out_valid), .result(result), .carry(carry),
    .ovf_sticky(ovf_sticky), .acc(acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic       sat;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_carry"}, carry, 0);
    chk({tag, "_ovf_sticky"}, ovf_sticky, 0);
    chk({tag, "_acc"}, acc, 0);
  endtask

  task automatic model_op(input bit [1:0] o, input bit s, input int ia, input int ib,
                          input int iacc, output int r, output bit c);
    int x, y;
    x = o[1] ? iacc : ia;
    y = o[1] ? ia : ib;
    if (!o[0]) begin
      r = x + y;
      c = (r > 255);
      if (c) r = s ? 255 : r - 256;
    end else begin
      r = x - y;
      c = (r < 0);
      if (c) r = s ? 0 : r + 256;
    end
  endtask

  initial begin
    int er[4];
    int ec[4];
    int m_acc, m_res, m_a, m_b, r;
    bit m_ov, m_car, m_sticky, m_s1v, m_sat, c;
    bit [1:0] m_op;

    vecs[0] = '{2'b00, 1'b0, 8'd200, 8'd100, 8'd44,  1'b1};
    vecs[1] = '{2'b00, 1'b1, 8'd200, 8'd100, 8'd255, 1'b1};
    vecs[2] = '{2'b01, 1'b0, 8'd5,   8'd9,   8'd252, 1'b1};
    vecs[3] = '{2'b01, 1'b1, 8'd5,   8'd9,   8'd0,   1'b1};
    vecs[4] = '{2'b00, 1'b0, 8'd3,   8'd4,   8'd7,   1'b0};
    vecs[5] = '{2'b01, 1'b0, 8'd9,   8'd5,   8'd4,   1'b0};
    vecs[6] = '{2'b00, 1'b0, 8'd255, 8'd1,   8'd0,   1'b1};
    vecs[7] = '{2'b00, 1'b1, 8'd255, 8'd0,   8'd255, 1'b0};
    vecs[8] = '{2'b01, 1'b1, 8'd0,   8'd0,   8'd0,   1'b0};

    // Reset values
    repeat (2) step();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    step();
    chk("post_reset_out_valid", out_valid, 0);

    // ADD/SUB wrap and saturate, two-cycle latency
    for (int i = 0; i < 9; i++) begin
      op = vecs[i].op; sat = vecs[i].sat; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_early_out_valid", i), out_valid, 0);
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].r);
      chk($sformatf("vec%0d_carry", i), carry, vecs[i].c);
      if (i == 0) chk("vec0_ovf_sticky", ovf_sticky, 1);
      chk($sformatf("vec%0d_acc_untouched", i), acc, 0);
      step();
      chk($sformatf("vec%0d_single_pulse", i), out_valid, 0);
    end

    // Back-to-back accumulate after clr, then DACC
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("acc_clr_acc", acc, 0);
    chk("acc_clr_sticky", ovf_sticky, 0);
    er = '{100, 200, 44, 250};
    ec = '{0, 0, 1, 1};
    sat = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      op = (i < 3) ? 2'b10 : 2'b11;
      a = (i < 3) ? 8'd100 : 8'd50;
      step();
      if (i >= 1) begin
        chk($sformatf("acc%0d_out_valid", i - 1), out_valid, 1);
        chk($sformatf("acc%0d_result", i - 1), result, er[i-1]);
        chk($sformatf("acc%0d_carry", i - 1), carry, ec[i-1]);
        chk($sformatf("acc%0d_acc", i - 1), acc, er[i-1]);
      end
    end
    in_valid = 1'b0;
    step();
    chk("acc_done_out_valid", out_valid, 0);
    chk("acc_sticky", ovf_sticky, 1);

    // clr colliding with an ACC in S2
    clr = 1'b1;
    step();
    clr = 1'b0;
    op = 2'b10; a = 8'd10; in_valid = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_hit_out_valid", out_valid, 1);
    chk("clr_hit_result", result, 10);
    chk("clr_hit_acc", acc, 0);
    chk("clr_hit_sticky", ovf_sticky, 0);
    step();
    chk("clr_hit_acc_next", acc, 0);
    chk("clr_hit_sticky_next", ovf_sticky, 0);

    // clr also overrides a same-cycle carry
    op = 2'b10; a = 8'd250; in_valid = 1'b1;
    step();
    a = 8'd10;
    step();
    in_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_carry_result", result, 4);
    chk("clr_carry_carry", carry, 1);
    chk("clr_carry_acc", acc, 0);
    chk("clr_carry_sticky", ovf_sticky, 0);

    // ena stall while the op sits in S1
    step();
    op = 2'b00; a = 8'd1; b = 8'd2; sat = 1'b0; in_valid = 1'b1; ena = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 1) begin
        in_valid = 1'b0;
        ena = 1'b0;
      end
      if (e == 4) ena = 1'b1;
      chk($sformatf("stall_e%0d_out_valid", e), out_valid, (e == 5));
      if (e == 5) chk("stall_result", result, 3);
    end

    // Async reset with ops in flight
    op = 2'b00; a = 8'd7; b = 8'd7; in_valid = 1'b1;
    step();
    a = 8'd9; b = 8'd9;
    #2 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk_zero_outputs("async_rst");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rst_release%0d_out_valid", i), out_valid, 0);
      chk($sformatf("rst_release%0d_result", i), result, 0);
    end

    // Random mixed stream against a reference model
    m_acc = 0; m_res = 0; m_a = 0; m_b = 0; m_ov = 0; m_car = 0; m_sticky = 0;
    m_s1v = 0; m_sat = 0; m_op = 0;
    for (int n = 0; n < 10000; n++) begin
      ena = ($urandom_range(7) != 0);
      in_valid = ($urandom_range(3) != 0);
      op = 2'($urandom_range(3));
      sat = 1'($urandom_range(1));
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      clr = ($urandom_range(31) == 0);
      if (ena) begin
        if (m_s1v) begin
          model_op(m_op, m_sat, m_a, m_b, m_acc, r, c);
          m_res = r;
          m_car = c;
          if (m_op[1]) m_acc = r;
          if (c) m_sticky = 1;
        end
        m_ov = m_s1v;
        if (clr) begin
          m_acc = 0;
          m_sticky = 0;
        end
        m_s1v = in_valid;
        if (in_valid) begin
          m_op = op; m_sat = sat; m_a = a; m_b = b;
        end
      end
      step();
      chk($sformatf("rnd%0d_out_valid", n), out_valid, m_ov);
      chk($sformatf("rnd%0d_result", n), result, m_res);
      chk($sformatf("rnd%0d_carry", n), carry, m_car);
      chk($sformatf("rnd%0d_acc", n), acc, m_acc);
      chk($sformatf("rnd%0d_ovf_sticky", n), ovf_sticky, m_sticky);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
